// File: rtl/path_merge_2way_pkg.sv
// path_merge_2way_pkg: shared NoC geometry, dy field insertion and merge source ids
package path_merge_2way_pkg;
  localparam int NOC_DATA_WIDTH = 23;
  localparam int NOC_DY_MSB = 20;
  localparam int NOC_DY_LSB = 12;
  localparam int NOC_BUFFER_DEPTH = 4;
  typedef enum logic {SRC_THRU = 1'b0, SRC_LOCAL = 1'b1} src_e;
  function automatic int dy_width(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction
  function automatic int local_width(input int dw, input int msb, input int lsb);
    return dw - dy_width(msb, lsb);
  endfunction
  // Shift-based insert so an empty upper slice (DY_MSB at the top) needs no special case
  function automatic logic [63:0] insert_dy(input logic [63:0] pkt, input logic [63:0] dy,
                                            input int msb, input int lsb);
    return ((pkt >> lsb) << (msb + 1)) | (dy << lsb) | (pkt & ((64'd1 << lsb) - 64'd1));
  endfunction
endpackage

// File: rtl/path_merge_2way_fifo.sv
// packet_fifo: synchronous FIFO with registered full flag; overflowing pushes are ignored
module packet_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, do_push, do_pop;
  assign do_push = push_i && !full_q;
  assign do_pop = pop_i && !empty_o;
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign empty_o = cnt_q == '0;
  assign full_o = full_q;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
      full_q <= cnt_d == (AW+1)'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/path_merge_2way.sv
// path_merge_2way: merges through traffic with dy-tagged local injections into one
// registered output stream using a round-robin arbiter over two packet FIFOs
module path_merge_2way
  import path_merge_2way_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DY_MSB = NOC_DY_MSB,
  parameter int DY_LSB = NOC_DY_LSB,
  parameter int BUFFER_DEPTH = NOC_BUFFER_DEPTH,
  localparam int DY_W = dy_width(DY_MSB, DY_LSB),
  localparam int LOCAL_W = local_width(DATA_WIDTH, DY_MSB, DY_LSB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_thru,
  input  logic                  wen_thru,
  output logic                  full_thru,
  input  logic [LOCAL_W-1:0]    din_local,
  input  logic [DY_W-1:0]       dy_local,
  input  logic                  wen_local,
  output logic                  full_local,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  wen_out,
  input  logic                  out_full,
  output logic                  err_overflow,
  output logic                  err_dy_zero
);
  logic [DATA_WIDTH-1:0] head_thru, head_local, local_pkt, dout_q;
  logic empty_thru, empty_local, grant, push_local, dy_zero, wen_q, err_ovf_q, err_dyz_q;
  src_e sel, rr_q, rr_d;
  assign dy_zero = dy_local == '0;
  assign push_local = wen_local && !dy_zero;
  assign local_pkt = DATA_WIDTH'(insert_dy(64'(din_local), 64'(dy_local), DY_MSB, DY_LSB));
  assign grant = !out_full && !(empty_thru && empty_local);
  assign sel = empty_thru ? SRC_LOCAL : (empty_local ? SRC_THRU : rr_q);
  assign rr_d = (sel == SRC_THRU) ? SRC_LOCAL : SRC_THRU;
  packet_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) u_thru (
    .clk(clk), .rst(rst), .push_i(wen_thru), .din_i(din_thru),
    .pop_i(grant && sel == SRC_THRU), .full_o(full_thru), .empty_o(empty_thru), .head_o(head_thru)
  );
  packet_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) u_local (
    .clk(clk), .rst(rst), .push_i(push_local), .din_i(local_pkt),
    .pop_i(grant && sel == SRC_LOCAL), .full_o(full_local), .empty_o(empty_local), .head_o(head_local)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= SRC_THRU;
      dout_q <= '0;
      wen_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_dyz_q <= 1'b0;
    end else begin
      wen_q <= grant;
      if (grant) begin
        dout_q <= (sel == SRC_LOCAL) ? head_local : head_thru;
        rr_q <= rr_d;
      end
      if ((wen_thru && full_thru) || (push_local && full_local)) err_ovf_q <= 1'b1;
      if (wen_local && dy_zero) err_dyz_q <= 1'b1;
    end
  end
  assign dout = dout_q;
  assign wen_out = wen_q;
  assign err_overflow = err_ovf_q;
  assign err_dy_zero = err_dyz_q;
endmodule

// File: tb/tb_path_merge_2way.sv
// tb_path_merge_2way: directed stimulus with an expected-packet queue checked on every wen_out
module tb_path_merge_2way;
  logic clk = 1'b0, rst;
  logic [22:0] din_thru, dout;
  logic [13:0] din_local;
  logic [8:0] dy_local;
  logic wen_thru, wen_local, out_full, full_thru, full_local, wen_out, err_overflow, err_dy_zero;
  logic of_edge = 1'b0;
  logic [22:0] exp_q[$];
  int n_chk = 0, n_err = 0;
  path_merge_2way dut (
    .clk(clk), .rst(rst), .din_thru(din_thru), .wen_thru(wen_thru), .full_thru(full_thru),
    .din_local(din_local), .dy_local(dy_local), .wen_local(wen_local), .full_local(full_local),
    .dout(dout), .wen_out(wen_out), .out_full(out_full),
    .err_overflow(err_overflow), .err_dy_zero(err_dy_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [22:0] pack_local(input logic [13:0] d, input logic [8:0] dy);
    return {d[13:12], dy, d[11:0]};
  endfunction
  always @(posedge clk) of_edge = out_full;
  always @(negedge clk) begin
    if (wen_out === 1'b1) begin
      chk("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("dout", 32'(dout), 32'(exp_q.pop_front()));
      chk("grant_with_out_full", 32'(of_edge), 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    int idx, cyc;
    rst = 1'b1;
    din_thru = '0; wen_thru = 1'b0; din_local = '0; dy_local = '0; wen_local = 1'b0; out_full = 1'b0;
    tick;
    tick;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_wen_out", 32'(wen_out), 0);
    chk("rst_full_thru", 32'(full_thru), 0);
    chk("rst_full_local", 32'(full_local), 0);
    chk("rst_err_ovf", 32'(err_overflow), 0);
    chk("rst_err_dyz", 32'(err_dy_zero), 0);
    rst = 1'b0;
    // single local injection: dy inserted, two-cycle latency, one-cycle pulse
    din_local = 14'h2ABC; dy_local = 9'h1FF; wen_local = 1'b1;
    exp_q.push_back(pack_local(din_local, dy_local));
    chk("pack_ref", 32'(pack_local(din_local, dy_local)), 32'h5FFABC);
    tick;
    wen_local = 1'b0;
    chk("t1_lat1", 32'(wen_out), 0);
    tick;
    chk("t1_wen", 32'(wen_out), 1);
    tick;
    chk("t1_pulse", 32'(wen_out), 0);
    // both FIFOs hold 3 packets: strict T,L alternation starting with thru
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_thru = 23'($urandom); wen_thru = 1'b1;
      din_local = 14'($urandom); dy_local = 9'(i + 1); wen_local = 1'b1;
      exp_q.push_back(din_thru);
      exp_q.push_back(pack_local(din_local, dy_local));
      tick;
    end
    wen_thru = 1'b0; wen_local = 1'b0;
    chk("t2_not_full", 32'(full_thru), 0);
    out_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t2_stream", 32'(wen_out), 1);
    end
    tick;
    chk("t2_end", 32'(wen_out), 0);
    chk("t2_drained", 32'(exp_q.size()), 0);
    // thru FIFO full: fifth write dropped, overflow flagged, four packets out
    out_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_thru = 23'h100000 + 23'(i); wen_thru = 1'b1;
      exp_q.push_back(din_thru);
      tick;
    end
    wen_thru = 1'b0;
    chk("t3_full", 32'(full_thru), 1);
    chk("t3_no_ovf_yet", 32'(err_overflow), 0);
    din_thru = 23'h7FFFFF; wen_thru = 1'b1;
    tick;
    wen_thru = 1'b0;
    chk("t3_ovf", 32'(err_overflow), 1);
    out_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t3_drain", 32'(wen_out), 1);
    end
    tick;
    chk("t3_end", 32'(wen_out), 0);
    chk("t3_full_clr", 32'(full_thru), 0);
    chk("t3_drained", 32'(exp_q.size()), 0);
    // dy==0 local write is rejected
    din_local = 14'h1234; dy_local = 9'h000; wen_local = 1'b1;
    tick;
    wen_local = 1'b0;
    chk("t4_dyz", 32'(err_dy_zero), 1);
    chk("t4_lat1", 32'(wen_out), 0);
    tick;
    chk("t4_no_out", 32'(wen_out), 0);
    // out_full toggling against an 8-packet thru stream
    out_full = 1'b1; idx = 0; cyc = 0;
    while ((idx < 8 || exp_q.size() != 0) && cyc < 60) begin
      if (idx < 8 && !full_thru) begin
        din_thru = 23'($urandom); wen_thru = 1'b1;
        exp_q.push_back(din_thru);
        idx++;
      end else wen_thru = 1'b0;
      tick;
      out_full = ~out_full;
      cyc++;
    end
    wen_thru = 1'b0; out_full = 1'b0;
    chk("t5_sent", 32'(idx), 8);
    chk("t5_drained", 32'(exp_q.size()), 0);
    chk("t5_in_time", 32'(cyc < 60), 1);
    // reset with packets buffered after a thru grant left rr pointing at local
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_thru = 23'h200000 + 23'(i); wen_thru = 1'b1;
      tick;
    end
    wen_thru = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_wen", 32'(wen_out), 0);
    chk("t6_full", 32'(full_thru), 0);
    chk("t6_ovf_clr", 32'(err_overflow), 0);
    chk("t6_dyz_clr", 32'(err_dy_zero), 0);
    out_full = 1'b0;
    tick;
    chk("t6_empty1", 32'(wen_out), 0);
    tick;
    chk("t6_empty2", 32'(wen_out), 0);
    out_full = 1'b1;
    din_thru = 23'h0ABCDE; wen_thru = 1'b1;
    din_local = 14'h3001; dy_local = 9'h101; wen_local = 1'b1;
    exp_q.push_back(din_thru);
    exp_q.push_back(pack_local(din_local, dy_local));
    tick;
    wen_thru = 1'b0; wen_local = 1'b0; out_full = 1'b0;
    tick;
    chk("t6_first", 32'(wen_out), 1);
    chk("t6_thru_first", 32'(dout), 32'h0ABCDE);
    tick;
    chk("t6_second", 32'(wen_out), 1);
    tick;
    chk("t6_end", 32'(wen_out), 0);
    chk("t6_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
